// File: rtl/if_id_fetch_buffer.sv
// if_id_fetch_buffer: decoupling FIFO between instruction fetch and decode.
// Holds up to DEPTH {pc, instr} pairs and presents the oldest one to decode.
// Fetch is throttled only by registered state (if_ready never depends on
// id_ready), so a full buffer admits a new word one cycle after a pop.
// A flush discards every buffered word and any word offered in the same cycle.
// Optional feature macro: FETCHBUF_PERF_EN adds the stall_cnt port, which
// counts the cycles in which decode held a valid head.
module if_id_fetch_buffer #(
    parameter int          DEPTH     = 2,
    parameter int          PC_W      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     if_valid,
    input  logic [PC_W-1:0]          if_pc,
    input  logic [31:0]              if_instr,
    output logic                     if_ready,
    input  logic                     id_ready,
    input  logic                     flush,
    output logic [31:0]              instrD,
    output logic [PC_W-1:0]          pcD,
    output logic                     validD,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef FETCHBUF_PERF_EN
    ,
    output logic [31:0]              stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Entry storage; contents need no reset because validD masks them.
    logic [PC_W-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            push;
    logic            pop;

    // Handshake and head presentation, all derived from registered state.
    always_comb begin
        if_ready  = (count != CW'(DEPTH));
        validD    = (count != '0);
        occupancy = count;
        push      = if_valid && if_ready;
        pop       = validD && id_ready;
        if (validD) begin
            instrD = instr_mem[rd_ptr];
            pcD    = pc_mem[rd_ptr];
        end else begin
            instrD = NOP_INSTR;
            pcD    = '0;
        end
    end

    // Capture an accepted word at the write pointer (flush drops it).
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[wr_ptr]    <= if_pc;
            instr_mem[wr_ptr] <= if_instr;
        end
    end

    // Pointer and count update; flush outranks push and pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FETCHBUF_PERF_EN
    // Decode-stall counter: wraps naturally, cleared only by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if (validD && !id_ready && !flush) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
// Self-checking bench for if_id_fetch_buffer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_if_id_fetch_buffer;

    localparam int          DEPTH = 2;
    localparam int          PC_W  = 32;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   if_valid;
    logic [PC_W-1:0]        if_pc;
    logic [31:0]            if_instr;
    logic                   if_ready;
    logic                   id_ready;
    logic                   flush;
    logic [31:0]            instrD;
    logic [PC_W-1:0]        pcD;
    logic                   validD;
    logic [$clog2(DEPTH):0] occupancy;
`ifdef FETCHBUF_PERF_EN
    logic [31:0]            stall_cnt;
`endif

    if_id_fetch_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .NOP_INSTR(NOP)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .if_valid  (if_valid),
        .if_pc     (if_pc),
        .if_instr  (if_instr),
        .if_ready  (if_ready),
        .id_ready  (id_ready),
        .flush     (flush),
        .instrD    (instrD),
        .pcD       (pcD),
        .validD    (validD),
        .occupancy (occupancy)
`ifdef FETCHBUF_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the buffer is an ordered list of words.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_stall;
    int          vectors;
    int          errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the model, given the inputs seen at that edge.
    task automatic model_step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                              input logic rdy, input logic fl);
        int  sz;
        sz = q.size();
        if (sz != 0 && !rdy && !fl) m_stall = m_stall + 32'd1;
        if (fl) begin
            q.delete();
        end else begin
            if (sz != 0 && rdy) void'(q.pop_front());
            if (v && sz < DEPTH) q.push_back('{pc: pc, instr: ins});
        end
    endtask

    task automatic check_all();
        chk("validD", {63'd0, validD}, {63'd0, q.size() != 0});
        chk("if_ready", {63'd0, if_ready}, {63'd0, q.size() < DEPTH});
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        if (q.size() != 0) begin
            chk("instrD", 64'(instrD), 64'(q[0].instr));
            chk("pcD", 64'(pcD), 64'(q[0].pc));
        end else begin
            chk("instrD_empty", 64'(instrD), 64'(NOP));
            chk("pcD_empty", 64'(pcD), 64'd0);
        end
`ifdef FETCHBUF_PERF_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    endtask

    // Apply inputs, take one edge, update the model, check #1 after the edge.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic rdy, input logic fl);
        if_valid = v;
        if_pc    = pc;
        if_instr = ins;
        id_ready = rdy;
        flush    = fl;
        @(posedge clk);
        model_step(v, pc, ins, rdy, fl);
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] cur_pc;
        logic [31:0] cur_ins;
        logic        v;
        logic        rdy;
        logic        fl;

        vectors  = 0;
        errors   = 0;
        m_stall  = 32'd0;
        rstn     = 1'b0;
        if_valid = 1'b0;
        if_pc    = '0;
        if_instr = '0;
        id_ready = 1'b0;
        flush    = 1'b0;

        // Reset then idle.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_validD", {63'd0, validD}, 64'd0);
        chk("rst_instrD", 64'(instrD), 64'h13);
        chk("rst_pcD", 64'(pcD), 64'd0);
        chk("rst_if_ready", {63'd0, if_ready}, 64'd1);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
`ifdef FETCHBUF_PERF_EN
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;
        check_all();

        // Single word, consumed immediately.
        cycle(1'b1, 32'h0, 32'h00500093, 1'b1, 1'b0);
        chk("single_valid", {63'd0, validD}, 64'd1);
        chk("single_instr", 64'(instrD), 64'h00500093);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("single_gone", {63'd0, validD}, 64'd0);

        // Fill under stall, third word refused, then drain in order.
        cycle(1'b1, 32'h4, 32'h00A00113, 1'b0, 1'b0);
        cycle(1'b1, 32'h8, 32'h00B00193, 1'b0, 1'b0);
        chk("fill_occ", 64'(occupancy), 64'd2);
        chk("fill_ready", {63'd0, if_ready}, 64'd0);
        chk("fill_head", 64'(instrD), 64'h00A00113);
        cycle(1'b1, 32'hC, 32'h00C00213, 1'b0, 1'b0);
        chk("full_refuse_occ", 64'(occupancy), 64'd2);
        chk("full_hold_head", 64'(instrD), 64'h00A00113);
        cycle(1'b1, 32'hC, 32'h00C00213, 1'b1, 1'b0);
        chk("drain_second", 64'(instrD), 64'h00B00193);
        chk("drain_no_admit", 64'(occupancy), 64'd1);
        cycle(1'b1, 32'hC, 32'h00C00213, 1'b1, 1'b0);
        chk("drain_third", 64'(instrD), 64'h00C00213);
        chk("drain_third_pc", 64'(pcD), 64'hC);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("drain_empty", {63'd0, validD}, 64'd0);

        // Streaming: one word per cycle, occupancy stays at 1.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 1'b1, 1'b0);
            chk("stream_instr", 64'(instrD), 64'h1000 + 64'(i));
            chk("stream_occ", 64'(occupancy), 64'd1);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with a simultaneous push.
        cycle(1'b1, 32'h20, 32'h11111111, 1'b0, 1'b0);
        cycle(1'b1, 32'h24, 32'h22222222, 1'b0, 1'b0);
        chk("preflush_occ", 64'(occupancy), 64'd2);
        cycle(1'b1, 32'h40, 32'h33333333, 1'b0, 1'b1);
        chk("flush_valid", {63'd0, validD}, 64'd0);
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_ready", {63'd0, if_ready}, 64'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("flush_word_absent", {63'd0, validD}, 64'd0);

        // Randomized traffic; fetch holds a refused word.
        cur_pc  = 32'h2000;
        cur_ins = $urandom;
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(3) != 0);
            rdy = ($urandom_range(2) != 0);
            fl  = ($urandom_range(15) == 0);
            if (v && q.size() < DEPTH && !fl) begin
                cycle(v, cur_pc, cur_ins, rdy, fl);
                cur_pc  = cur_pc + 32'd4;
                cur_ins = $urandom;
            end else begin
                cycle(v, cur_pc, cur_ins, rdy, fl);
                if (fl) begin
                    cur_pc  = 32'h3000 + 32'($urandom_range(255) * 4);
                    cur_ins = $urandom;
                end
            end
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);

        // Asynchronous reset while one word is buffered.
        cycle(1'b1, 32'h80, 32'h0AA00513, 1'b0, 1'b0);
        chk("pre_areset_occ", 64'(occupancy), 64'd1);
        if_valid = 1'b0;
        id_ready = 1'b0;
        #2 rstn = 1'b0;
        #1;
        q.delete();
        m_stall = 32'd0;
        chk("areset_valid", {63'd0, validD}, 64'd0);
        chk("areset_instr", 64'(instrD), 64'h13);
        chk("areset_pc", 64'(pcD), 64'd0);
        chk("areset_occ", 64'(occupancy), 64'd0);
        chk("areset_ready", {63'd0, if_ready}, 64'd1);
`ifdef FETCHBUF_PERF_EN
        chk("areset_stall", 64'(stall_cnt), 64'd0);
`endif
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;
        check_all();

        // Hold a head for five cycles.
        cycle(1'b1, 32'h90, 32'h0BB00593, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            chk("hold_head", 64'(instrD), 64'h0BB00593);
        end
`ifdef FETCHBUF_PERF_EN
        chk("stall_cnt_5", 64'(stall_cnt), 64'd5);
`endif
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/if_id_fetch_buffer.md
Name: if_id_fetch_buffer

Overview:
- Decoupling buffer between the instruction-fetch stage and the decode (ID) stage.
- Accepts {pc, instr} pairs from instruction memory and presents the oldest one as instrD/pcD to decode, including the immediate extender.
- Absorbs decode stalls without dropping fetched words.
- Discards all buffered words on a control-flow redirect (flush).

Parameters:
- DEPTH, 2, number of buffered entries; power of two, 2..8.
- PC_W, 32, PC width.
- NOP_INSTR, 32'h00000013, word driven on instrD when no valid entry (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- if_valid  input  1  fetch offers a word this cycle
- if_pc  input  PC_W  PC of offered word
- if_instr  input  32  offered instruction word
- if_ready  output  1  buffer can accept a word this cycle
- id_ready  input  1  decode consumes head this cycle (= !stallD)
- flush  input  1  redirect; discard all entries
- instrD  output  32  head instruction, or NOP_INSTR when empty
- pcD  output  PC_W  head PC, or 0 when empty
- validD  output  1  head entry is valid
- occupancy  output  $clog2(DEPTH)+1  current entry count
- stall_cnt  output  32  present only with FETCHBUF_PERF_EN

Behaviour:
- Reset (rstn=0, asynchronous):
  - Read/write pointers = 0, count = 0.
  - validD = 0, instrD = NOP_INSTR, pcD = 0, if_ready = 1, occupancy = 0, stall_cnt = 0.
- Storage: circular FIFO of DEPTH entries, each {pc, instr}. Pointers wrap modulo DEPTH. The count is held separately so full and empty are distinguishable.
- Push: if_valid && if_ready at a rising edge writes the entry at the write pointer, then increments it.
- Pop: validD && id_ready at a rising edge increments the read pointer.
- if_ready = (count != DEPTH). It is registered-state only, with no combinational path from id_ready.
  - Consequence: when full, a same-cycle pop does not admit a push; the push is admitted the next cycle.
- Simultaneous push and pop (count between 1 and DEPTH-1): count unchanged, both pointers advance.
- Latency: a word pushed at edge N appears on instrD/pcD/validD after edge N (first cycle N+1) if the buffer was empty. There is no same-cycle bypass.
- Outputs are driven combinationally from the head entry and count:
  - validD = (count != 0).
  - When empty: instrD = NOP_INSTR, pcD = 0.
- Head hold: while validD && !id_ready, instrD and pcD stay stable, and the FIFO order of stored words is preserved.
- Flush (synchronous, sampled at the rising edge):
  - Pointers and count are set to 0.
  - Flush has priority over push and pop; a word offered in the flush cycle is dropped.
  - First cycle after flush: validD = 0, if_ready = 1.
- if_valid while if_ready = 0: the word is not captured; fetch must hold it.
- occupancy = count, 0..DEPTH.

Optional Feature:
- Macro: FETCHBUF_PERF_EN.
- Defined:
  - Port stall_cnt exists: a 32-bit counter that increments on each cycle with validD && !id_ready && !flush.
  - It wraps from 32'hFFFFFFFF to 0, is cleared by rstn only, and is unaffected by flush.
- Undefined: stall_cnt port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rstn low 3 cycles → validD = 0, instrD = 32'h00000013, pcD = 0, if_ready = 1, occupancy = 0.
- Single word: push pc=0x0000_0000, instr=0x00500093 with id_ready=1 → next cycle validD = 1, instrD = 0x00500093; following cycle validD = 0.
- Fill under stall: id_ready = 0, push 0x00A00113 @0x4 then 0x00B00193 @0x8 → occupancy = 2, if_ready = 0, instrD stays 0x00A00113. A third offered word is not accepted. Release id_ready → outputs 0x00A00113, 0x00B00193, then the third word, in order.
- Streaming: if_valid and id_ready held 1 for 10 words with PC incrementing by 4 → one word per cycle at the output, in order, none lost or duplicated, occupancy never exceeds 1.
- Flush with push: buffer holding 2 entries; assert flush and if_valid (pc 0x40) in the same cycle → next cycle validD = 0, occupancy = 0, word 0x40 absent.
- Async reset mid-stream, plus perf counter (with FETCHBUF_PERF_EN):
  - Drop rstn while occupancy = 1 → outputs return to reset values immediately, before the next clock edge.
  - Then hold head 5 cycles with id_ready = 0 → stall_cnt = 5.
